// File: rtl/axi_bw_resp_allocator.sv
// AXI write-response allocator: round-robin merge of N B channels onto one master port,
// outstanding-transaction tracking and in-order decode-error response injection.
module axi_bw_resp_allocator #(
  parameter int unsigned N_INIT_PORT = 4,
  parameter int unsigned AXI_ID_IN   = 16,
  parameter int unsigned AXI_ID_OUT  = AXI_ID_IN + $clog2(N_INIT_PORT),
  parameter int unsigned AXI_USER_W  = 6,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned ERR_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_INIT_PORT*AXI_ID_OUT-1:0] bid_i,
  input  logic [N_INIT_PORT*2-1:0]          bresp_i,
  input  logic [N_INIT_PORT*AXI_USER_W-1:0] buser_i,
  input  logic [N_INIT_PORT-1:0]            bvalid_i,
  output logic [N_INIT_PORT-1:0]            bready_o,
  output logic [AXI_ID_IN-1:0]              bid_o,
  output logic [1:0]                        bresp_o,
  output logic [AXI_USER_W-1:0]             buser_o,
  output logic                              bvalid_o,
  input  logic                              bready_i,
  input  logic                              incr_req_i,
  output logic                              full_counter_o,
  output logic                              outstanding_trans_o,
  input  logic                              error_req_i,
  output logic                              error_gnt_o,
  input  logic [AXI_ID_IN-1:0]              error_id_i,
  input  logic [AXI_USER_W-1:0]             error_user_i,
  output logic                              err_pending_o
);

  localparam int unsigned PW = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;
  localparam int unsigned AW = $clog2(ERR_DEPTH);
  localparam int unsigned EW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [EW-1:0]    ERR_FULL = EW'(ERR_DEPTH);

  typedef enum logic {OPERATIVE, ERROR_RESP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         lock_gnt;
  logic [PW-1:0]         gnt;
  logic                  lock;
  logic                  found;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [EW-1:0]         err_cnt;
  logic [EW-1:0]         err_cnt_next;
  logic [AXI_ID_IN-1:0]  err_id_mem   [ERR_DEPTH];
  logic [AXI_USER_W-1:0] err_user_mem [ERR_DEPTH];

  logic [AXI_ID_IN-1:0]  port_id   [N_INIT_PORT];
  logic [1:0]            port_resp [N_INIT_PORT];
  logic [AXI_USER_W-1:0] port_user [N_INIT_PORT];

  logic in_err;
  logic any_valid;
  logic hs_real;
  logic push;
  logic pop;
  logic unused_bid;

  // Unpack per-port payloads; ID bits above AXI_ID_IN carry the routing index and are dropped.
  for (genvar p = 0; p < N_INIT_PORT; p++) begin : g_port
    assign port_id[p]   = bid_i[p*AXI_ID_OUT +: AXI_ID_IN];
    assign port_resp[p] = bresp_i[p*2 +: 2];
    assign port_user[p] = buser_i[p*AXI_USER_W +: AXI_USER_W];
  end
  assign unused_bid = ^bid_i;

  assign in_err    = (state == ERROR_RESP);
  assign any_valid = |bvalid_i;
  assign hs_real   = !in_err && any_valid && bready_i;
  assign push      = error_req_i && error_gnt_o;
  assign pop       = in_err && bready_i;

  assign full_counter_o      = (cnt == CNT_MAX);
  assign outstanding_trans_o = (cnt != '0);
  assign error_gnt_o         = (err_cnt != ERR_FULL);
  assign err_pending_o       = (err_cnt != '0);

  // Round-robin search from rr_ptr; a stalled grant stays locked until it handshakes.
  always_comb begin
    gnt   = rr_ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < N_INIT_PORT; i++) begin
      int unsigned k;
      k = 32'(rr_ptr) + i;
      if (k >= N_INIT_PORT) k = k - N_INIT_PORT;
      if (!found && bvalid_i[PW'(k)]) begin
        gnt   = PW'(k);
        found = 1'b1;
      end
    end
    if (lock) gnt = lock_gnt;
  end

  always_comb begin
    cnt_next = cnt;
    if (incr_req_i && !hs_real && cnt != CNT_MAX)      cnt_next = cnt + CNT_W'(1);
    else if (hs_real && !incr_req_i && cnt != '0)      cnt_next = cnt - CNT_W'(1);
  end

  always_comb begin
    err_cnt_next = err_cnt;
    if (push && !pop)      err_cnt_next = err_cnt + EW'(1);
    else if (pop && !push) err_cnt_next = err_cnt - EW'(1);
  end

  // Output mux: real responses pass straight through, error responses come from the FIFO head.
  always_comb begin
    bvalid_o = 1'b0;
    bready_o = '0;
    bid_o    = port_id[gnt];
    bresp_o  = port_resp[gnt];
    buser_o  = port_user[gnt];
    if (in_err) begin
      bvalid_o = !rst;
      bresp_o  = 2'b11;
      bid_o    = err_id_mem[rd_ptr];
      buser_o  = err_user_mem[rd_ptr];
    end else if (!rst) begin
      bvalid_o = any_valid;
      if (any_valid) bready_o[gnt] = bready_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OPERATIVE;
      cnt      <= '0;
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_gnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err_cnt  <= '0;
    end else begin
      cnt     <= cnt_next;
      err_cnt <= err_cnt_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case (state)
        OPERATIVE: begin
          if (any_valid) begin
            if (bready_i) begin
              lock   <= 1'b0;
              rr_ptr <= (32'(gnt) == N_INIT_PORT - 1) ? '0 : gnt + PW'(1);
            end else begin
              lock     <= 1'b1;
              lock_gnt <= gnt;
            end
          end
          if (err_pending_o && cnt == '0 && !any_valid && !lock) state <= ERROR_RESP;
        end
        ERROR_RESP: begin
          // The presented error always completes before handing back to real traffic.
          if (bready_i && (err_cnt_next == '0 || cnt_next != '0)) state <= OPERATIVE;
        end
        default: state <= OPERATIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      err_id_mem[wr_ptr]   <= error_id_i;
      err_user_mem[wr_ptr] <= error_user_i;
    end
  end

endmodule

// File: tb/tb_axi_bw_resp_allocator.sv
// Randomized bench for axi_bw_resp_allocator against a queue-based reference model.
module tb_axi_bw_resp_allocator;

  localparam int unsigned N   = 4;
  localparam int unsigned IDI = 16;
  localparam int unsigned IDO = IDI + 2;
  localparam int unsigned UW  = 6;
  localparam int unsigned CW  = 2;
  localparam int          ED  = 4;
  localparam int          CMAX = (1 << CW) - 1;
  localparam int          NCYC = 3000;

  logic           clk;
  logic           rst;
  logic [N*IDO-1:0] bid_i;
  logic [N*2-1:0]   bresp_i;
  logic [N*UW-1:0]  buser_i;
  logic [N-1:0]     bvalid_i;
  logic [N-1:0]     bready_o;
  logic [IDI-1:0]   bid_o;
  logic [1:0]       bresp_o;
  logic [UW-1:0]    buser_o;
  logic             bvalid_o;
  logic             bready_i;
  logic             incr_req_i;
  logic             full_counter_o;
  logic             outstanding_trans_o;
  logic             error_req_i;
  logic             error_gnt_o;
  logic [IDI-1:0]   error_id_i;
  logic [UW-1:0]    error_user_i;
  logic             err_pending_o;

  axi_bw_resp_allocator #(
    .N_INIT_PORT(N), .AXI_ID_IN(IDI), .AXI_ID_OUT(IDO),
    .AXI_USER_W(UW), .CNT_W(CW), .ERR_DEPTH(ED)
  ) dut (
    .clk(clk), .rst(rst),
    .bid_i(bid_i), .bresp_i(bresp_i), .buser_i(buser_i), .bvalid_i(bvalid_i),
    .bready_o(bready_o), .bid_o(bid_o), .bresp_o(bresp_o), .buser_o(buser_o),
    .bvalid_o(bvalid_o), .bready_i(bready_i), .incr_req_i(incr_req_i),
    .full_counter_o(full_counter_o), .outstanding_trans_o(outstanding_trans_o),
    .error_req_i(error_req_i), .error_gnt_o(error_gnt_o), .error_id_i(error_id_i),
    .error_user_i(error_user_i), .err_pending_o(err_pending_o)
  );

  typedef struct packed {
    logic [IDI-1:0] id;
    logic [UW-1:0]  user;
  } err_t;

  // Upstream B sources: a response stays valid and stable until it is accepted.
  bit             src_v    [N];
  logic [IDO-1:0] src_id   [N];
  logic [1:0]     src_resp [N];
  logic [UW-1:0]  src_user [N];

  // Reference model state
  int   m_cnt;
  int   m_rr;
  int   m_lockp;
  bit   m_lock;
  bit   m_err;
  err_t m_q[$];

  int n_pass;
  int n_checks;
  int waited;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  function automatic bit any_src();
    for (int p = 0; p < N; p++) if (src_v[p]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick();
    if (m_lock) return m_lockp;
    for (int i = 0; i < N; i++) if (src_v[(m_rr + i) % N]) return (m_rr + i) % N;
    return 0;
  endfunction

  task automatic drive_bus();
    for (int p = 0; p < N; p++) begin
      bid_i[p*IDO +: IDO] = src_id[p];
      bresp_i[p*2 +: 2]   = src_resp[p];
      buser_i[p*UW +: UW] = src_user[p];
      bvalid_i[p]         = src_v[p];
    end
  endtask

  task automatic clear_sources();
    for (int p = 0; p < N; p++) begin
      src_v[p] = 1'b0; src_id[p] = '0; src_resp[p] = '0; src_user[p] = '0;
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rr = 0; m_lock = 1'b0; m_lockp = 0; m_err = 1'b0;
    m_q.delete();
  endtask

  task automatic check_outputs();
    bit any;
    int g;
    logic [N-1:0] er;
    any = any_src();
    g   = pick();
    er  = '0;
    if (rst) begin
      check("rst_bvalid", 32'(bvalid_o), 32'(0));
      check("rst_bready", 32'(bready_o), 32'(0));
    end else if (m_err) begin
      check("err_bvalid", 32'(bvalid_o), 32'(1));
      check("err_bready", 32'(bready_o), 32'(0));
      check("err_bresp",  32'(bresp_o),  32'(3));
      check("err_bid",    32'(bid_o),    32'(m_q[0].id));
      check("err_buser",  32'(buser_o),  32'(m_q[0].user));
    end else begin
      if (any) er[g] = bready_i;
      check("bvalid", 32'(bvalid_o), 32'(any));
      check("bready", 32'(bready_o), 32'(er));
      if (any) begin
        check("bid",   32'(bid_o),   32'(src_id[g][IDI-1:0]));
        check("bresp", 32'(bresp_o), 32'(src_resp[g]));
        check("buser", 32'(buser_o), 32'(src_user[g]));
      end
    end
    check("error_gnt",    32'(error_gnt_o),         32'(m_q.size() < ED));
    check("err_pending",  32'(err_pending_o),       32'(m_q.size() != 0));
    check("full_counter", 32'(full_counter_o),      32'(m_cnt == CMAX));
    check("outstanding",  32'(outstanding_trans_o), 32'(m_cnt != 0));
  endtask

  // Advance the model by one clock using the inputs present just before the edge.
  task automatic model_step();
    bit any, hs, pop, push, had_err;
    int g, old_cnt;
    bit old_lock;
    err_t e;
    any      = any_src();
    g        = pick();
    old_cnt  = m_cnt;
    old_lock = m_lock;
    had_err  = (m_q.size() != 0);
    hs   = !m_err && any && bready_i;
    pop  = m_err && bready_i;
    push = error_req_i && (m_q.size() < ED);
    if (incr_req_i && !hs)      m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
    else if (hs && !incr_req_i) m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      e.id = error_id_i; e.user = error_user_i;
      m_q.push_back(e);
    end
    if (!m_err) begin
      if (hs) begin
        src_v[g] = 1'b0; m_lock = 1'b0; m_rr = (g + 1) % N;
      end else if (any) begin
        m_lock = 1'b1; m_lockp = g;
      end
      if (had_err && old_cnt == 0 && !any && !old_lock) m_err = 1'b1;
    end else if (bready_i) begin
      m_err = (m_q.size() != 0) && (m_cnt == 0);
    end
  endtask

  // Phases: busy traffic, light traffic, and a drain phase that lets the counter reach zero.
  task automatic stimulate(input int cyc);
    int ph, nv;
    ph = (cyc / 200) % 3;
    nv = 0;
    for (int p = 0; p < N; p++) if (src_v[p]) nv++;
    for (int p = 0; p < N; p++) begin
      if (!src_v[p]) begin
        bit spawn;
        case (ph)
          0:       spawn = $urandom_range(0, 99) < 40;
          1:       spawn = $urandom_range(0, 99) < 15;
          default: spawn = (m_cnt > nv) && ($urandom_range(0, 99) < 50);
        endcase
        if (spawn) begin
          src_v[p] = 1'b1; nv++;
          src_id[p] = IDO'($urandom); src_resp[p] = 2'($urandom); src_user[p] = UW'($urandom);
        end
      end
    end
    incr_req_i   = (ph == 0) ? ($urandom_range(0, 99) < 40) :
                   (ph == 1) ? ($urandom_range(0, 99) < 10) : 1'b0;
    bready_i     = $urandom_range(0, 99) < 70;
    error_req_i  = $urandom_range(0, 99) < ((ph == 2) ? 10 : 25);
    error_id_i   = IDI'($urandom);
    error_user_i = UW'($urandom);
    drive_bus();
  endtask

  task automatic run_cycle();
    @(negedge clk); check_outputs();
    @(posedge clk); model_step();
    #1;
  endtask

  initial begin
    n_pass = 0; n_checks = 0;
    rst = 1'b1; bready_i = 1'b0; incr_req_i = 1'b0; error_req_i = 1'b0;
    error_id_i = '0; error_user_i = '0;
    clear_sources(); drive_bus(); model_reset();
    @(negedge clk); check_outputs();
    @(posedge clk); #1 rst = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc % 700 == 650) begin
        // Reset mid-traffic with sources still asserting valid: outputs must be gated off.
        rst = 1'b1; model_reset();
        @(negedge clk); check_outputs();
        @(posedge clk); #1;
        rst = 1'b0; clear_sources(); drive_bus();
      end
      stimulate(cyc);
      run_cycle();
    end

    // Two queued errors, then reset while the first one is on the bus.
    rst = 1'b1; model_reset(); clear_sources();
    bready_i = 1'b0; incr_req_i = 1'b0; error_req_i = 1'b0; drive_bus();
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      error_req_i = 1'b1; error_id_i = IDI'(5 + i); error_user_i = 6'h2A;
      run_cycle();
    end
    error_req_i = 1'b0;
    waited = 0;
    while (bvalid_o !== 1'b1 && waited < 8) begin
      run_cycle();
      waited++;
    end
    check("err_entry_bvalid", 32'(bvalid_o), 32'(1));
    run_cycle();
    rst = 1'b1; model_reset();
    #1;
    check("rst_err_bvalid",  32'(bvalid_o),      32'(0));
    check("rst_err_pending", 32'(err_pending_o), 32'(0));
    check("rst_err_gnt",     32'(error_gnt_o),   32'(1));
    @(negedge clk); check_outputs();
    @(posedge clk); #1 rst = 1'b0;
    src_v[1] = 1'b1; src_id[1] = IDO'(18'h2_1234); src_resp[1] = 2'b01; src_user[1] = 6'h11;
    bready_i = 1'b1; drive_bus();
    run_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
